// File: rtl/ball_detect_pkg.sv
// Shared grid geometry, FSM state and result payload for the per-frame ball search.
package ball_detect_pkg;

  localparam int unsigned X_START    = 144;
  localparam int unsigned Y_START    = 34;
  localparam int unsigned VGA_WIDTH  = 640;
  localparam int unsigned VGA_HEIGHT = 480;
  localparam int unsigned VGA_CNT_W  = 13;
  localparam int unsigned BLOCK_SIZE = 16;
  localparam int unsigned BLK_LOG2   = $clog2(BLOCK_SIZE);
  localparam int unsigned COLS       = VGA_WIDTH / BLOCK_SIZE;
  localparam int unsigned ROWS       = VGA_HEIGHT / BLOCK_SIZE;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned MIN_COUNT  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    SCAN    = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  typedef struct packed {
    logic [COL_W-1:0] x;
    logic [ROW_W-1:0] y;
    logic [CNT_W-1:0] count;
    logic             found;
  } ball_result_t;

endpackage

// File: rtl/column_counter_bank.sv
// One saturating hit counter per grid column, with an increment port and a
// serial read-and-clear port used by the blanking-time scan.
module column_counter_bank
  import ball_detect_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr_all,
  input  logic             i_inc,
  input  logic [COL_W-1:0] i_inc_col,
  input  logic             i_rd_clr,
  input  logic [COL_W-1:0] i_rd_col,
  output logic [CNT_W-1:0] o_rd_cnt_c
);

  logic [CNT_W-1:0] r_cnt [COLS];

  // Bulk clear still admits the frame's first pixel so it is not lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < COLS; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (i_clr_all) begin
          r_cnt[c] <= (i_inc && (i_inc_col == COL_W'(c))) ? CNT_W'(1) : '0;
        end else if (i_rd_clr && (i_rd_col == COL_W'(c))) begin
          r_cnt[c] <= '0;
        end else if (i_inc && (i_inc_col == COL_W'(c)) && (r_cnt[c] != '1)) begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  assign o_rd_cnt_c = (i_rd_col < COL_W'(COLS)) ? r_cnt[i_rd_col] : '0;

endmodule

// File: rtl/ball_frame_scheduler.sv
// Per-frame ball search: accumulates classifier hits per strip, scans columns
// during horizontal blanking, and publishes the best cell over valid/ready.
module ball_frame_scheduler
  import ball_detect_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [VGA_CNT_W-1:0] VGA_H_CNT,
  input  logic [VGA_CNT_W-1:0] VGA_V_CNT,
  input  logic                 HIT,
  output logic [COL_W-1:0]     BALL_X,
  output logic [ROW_W-1:0]     BALL_Y,
  output logic [CNT_W-1:0]     BALL_COUNT,
  output logic                 BALL_FOUND,
  output logic                 BALL_VALID,
  input  logic                 BALL_READY,
  output logic                 DROPPED,
  output logic                 BUSY
);

  state_e                 r_state, w_state_nxt;
  logic [VGA_CNT_W-1:0]   w_x, w_y;
  logic                   w_active, w_frame_start, w_strip_end;
  logic [COL_W-1:0]       w_cx, r_scan_idx, r_best_x;
  logic [ROW_W-1:0]       w_ry, r_strip_row, r_best_y;
  logic [CNT_W-1:0]       w_rd_cnt, r_best_count;
  logic                   w_clr_all, w_inc, w_rd_clr, w_load_scan, w_abort, w_publish;
  ball_result_t           r_result;
  logic                   r_valid, r_dropped, r_busy;

  assign w_x      = VGA_H_CNT - VGA_CNT_W'(X_START);
  assign w_y      = VGA_V_CNT - VGA_CNT_W'(Y_START);
  assign w_active = (VGA_H_CNT >= VGA_CNT_W'(X_START)) && (w_x < VGA_CNT_W'(VGA_WIDTH)) &&
                    (VGA_V_CNT >= VGA_CNT_W'(Y_START)) && (w_y < VGA_CNT_W'(VGA_HEIGHT));
  assign w_cx     = COL_W'(w_x >> BLK_LOG2);
  assign w_ry     = ROW_W'(w_y >> BLK_LOG2);
  assign w_frame_start = ENABLE && w_active && (w_x == '0) && (w_y == '0);
  assign w_strip_end   = w_active && (w_x == VGA_CNT_W'(VGA_WIDTH - 1)) &&
                         (w_y[BLK_LOG2-1:0] == '1);

  column_counter_bank u_bank (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clr_all  (w_clr_all),
    .i_inc      (w_inc),
    .i_inc_col  (w_cx),
    .i_rd_clr   (w_rd_clr),
    .i_rd_col   (r_scan_idx),
    .o_rd_cnt_c (w_rd_cnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_all   = 1'b0;
    w_inc       = 1'b0;
    w_rd_clr    = 1'b0;
    w_load_scan = 1'b0;
    w_abort     = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr_all = 1'b1;
        if (w_frame_start) begin
          w_inc       = HIT;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!ENABLE) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_inc = HIT && w_active;
          if (w_strip_end) begin
            w_load_scan = 1'b1;
            w_state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (!ENABLE) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_rd_clr = 1'b1;
          if (r_scan_idx == COL_W'(COLS - 1)) begin
            w_state_nxt = (r_strip_row == ROW_W'(ROWS - 1)) ? PUBLISH : ACCUM;
          end
        end
      end
      PUBLISH: begin
        w_publish   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strict compare keeps the lowest column of the earliest strip on ties.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_scan_idx   <= '0;
      r_strip_row  <= '0;
      r_best_count <= '0;
      r_best_x     <= '0;
      r_best_y     <= '0;
      r_result     <= '0;
      r_valid      <= 1'b0;
      r_dropped    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      r_busy    <= (w_state_nxt != IDLE);
      if (w_load_scan) begin
        r_scan_idx  <= '0;
        r_strip_row <= w_ry;
      end else if (w_rd_clr) begin
        r_scan_idx <= r_scan_idx + COL_W'(1);
      end
      if (w_abort || w_publish) begin
        r_best_count <= '0;
        r_best_x     <= '0;
        r_best_y     <= '0;
      end else if (w_rd_clr && (w_rd_cnt > r_best_count)) begin
        r_best_count <= w_rd_cnt;
        r_best_x     <= r_scan_idx;
        r_best_y     <= r_strip_row;
      end
      if (w_publish) begin
        r_result  <= '{x: r_best_x, y: r_best_y, count: r_best_count,
                       found: (r_best_count >= CNT_W'(MIN_COUNT))};
        r_valid   <= 1'b1;
        r_dropped <= r_valid && !BALL_READY;
      end else if (r_valid && BALL_READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign BALL_X     = r_result.x;
  assign BALL_Y     = r_result.y;
  assign BALL_COUNT = r_result.count;
  assign BALL_FOUND = r_result.found;
  assign BALL_VALID = r_valid;
  assign DROPPED    = r_dropped;
  assign BUSY       = r_busy;

endmodule
